alu_seq: RTL

Parametrised, registered successor to the combinational 4-bit ALU. Accepts one operation at a time over a valid/ready handshake and computes add, sub, logic and shift operations in one cycle. Multiply and divide/modulo run iteratively over WIDTH cycles. The result and NZCV flags are held in output registers until the consumer takes them. It sits between the operand/opcode source (switches or a control FSM) and the display/flag logic.

---
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle add/sub/logic/shift, iterative mul and div/mod.
// Define ALU_SEQ_DIV_EN to build the restoring divider; otherwise div/mod return 0 with v=1.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       uc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready=1
  // EXEC  | iterative mul/div/mod, counter runs WIDTH steps
  // DONE  | result and flags held until out_ready
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                         OP_MOD = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
                         OP_SHL = 4'h8, OP_SHR = 4'h9;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
`ifdef ALU_SEQ_DIV_EN
  logic [3:0]         op_q, op_d;
`endif

  logic [WIDTH-1:0] res1;
  logic             n1, c1, v1, iter1;
  logic [WIDTH:0]   sum1, shl1, shr1;

  // The extra bit of each shift vector catches the last bit shifted out.
  always_comb begin
    res1  = '0;
    n1    = 1'b0;
    c1    = 1'b0;
    v1    = 1'b0;
    iter1 = 1'b0;
    sum1  = {1'b0, a} + {1'b0, b};
    shl1  = {1'b0, a} << b;
    shr1  = {a, 1'b0} >> b;
    case (uc)
      OP_ADD: begin res1 = sum1[WIDTH-1:0]; c1 = sum1[WIDTH]; end
      OP_SUB: begin n1 = (a < b); res1 = (a < b) ? b - a : a - b; end
      OP_MUL: iter1 = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      OP_DIV, OP_MOD: iter1 = 1'b1;
`else
      OP_DIV, OP_MOD: v1 = 1'b1;
`endif
      OP_AND: res1 = a & b;
      OP_OR:  res1 = a | b;
      OP_XOR: res1 = a ^ b;
      OP_SHL: begin res1 = shl1[WIDTH-1:0]; c1 = shl1[WIDTH]; end
      OP_SHR: begin res1 = shr1[WIDTH:1];   c1 = shr1[0]; end
      default: ;
    endcase
  end

  // Multiplier lives in acc low half, partial product accumulates in the high half.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx, acc_step;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_v;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_nx  = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
  // Restoring division: acc = {remainder, dividend/quotient}.
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] div_nx;

  assign rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge = (rem_sh >= {1'b0, b_q});
  assign rem_nx = div_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
  assign div_nx = {rem_nx, acc_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    acc_step = mul_nx;
    fin_res  = mul_nx[WIDTH-1:0];
    fin_v    = |mul_nx[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
    if (op_q != OP_MUL) begin
      acc_step = div_nx;
      fin_v    = (b_q == '0);
      if (fin_v)                fin_res = '0;
      else if (op_q == OP_DIV)  fin_res = div_nx[WIDTH-1:0];
      else                      fin_res = div_nx[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
`ifdef ALU_SEQ_DIV_EN
    op_d     = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (iter1) begin
            state_d = EXEC;
            cnt_d   = CW'(WIDTH);
            acc_d   = {{WIDTH{1'b0}}, a};
            b_d     = b;
`ifdef ALU_SEQ_DIV_EN
            op_d    = uc;
`endif
          end else begin
            state_d  = DONE;
            result_d = res1;
            n_d      = n1;
            z_d      = (res1 == '0);
            c_d      = c1;
            v_d      = v1;
          end
        end
      end
      EXEC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = fin_res;
          n_d      = 1'b0;
          z_d      = (fin_res == '0);
          c_d      = 1'b0;
          v_d      = fin_v;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
`ifdef ALU_SEQ_DIV_EN
      op_q     <= op_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign n         = n_q;
  assign z         = z_q;
  assign c         = c_q;
  assign v         = v_q;

endmodule
